// File: rtl/config_serial_loader_pkg.sv
// Shared definitions for the configuration serial loader: frame geometry,
// FSM state encoding and the assembled frame layout.
`timescale 1ns/1ps
package config_serial_loader_pkg;

  localparam int unsigned FRAME_BITS = 18;
  localparam int unsigned ADR_W      = 2;
  localparam int unsigned DAT_W      = 16;
  localparam int unsigned MUX_W      = 6;
  localparam int unsigned CNT_W      = 5;

  // Bit counter: a valid frame holds exactly CNT_FULL bits; the counter
  // stops at CNT_SAT so overlong frames stay distinguishable from valid ones.
  localparam logic [CNT_W-1:0] CNT_FULL = 5'd18;
  localparam logic [CNT_W-1:0] CNT_SAT  = 5'd19;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SHIFT  = 3'd1;
  localparam logic [2:0] ST_SETUP  = 3'd2;
  localparam logic [2:0] ST_STROBE = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
  } frame_t;

  // A write is being issued in any of the three bank-facing phases.
  function automatic logic is_busy_state(input logic [2:0] st);
    return (st == ST_SETUP) || (st == ST_STROBE) || (st == ST_HOLD);
  endfunction

endpackage

// File: rtl/cfg_sync_edge.sv
// Synchronizer chain for one asynchronous input with single-cycle rise/fall
// pulses derived from the synchronized level.
`timescale 1ns/1ps
module cfg_sync_edge
  import config_serial_loader_pkg::*;
#(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  // Next state of the chain and the delayed copy used for edge detection.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
    prev_d = sync_q[STAGES-1];
  end

  // Synchronizer and edge-history flops.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o =  q_o & ~prev_q;
  assign fall_o = ~q_o &  prev_q;

endmodule

// File: rtl/config_serial_loader.sv
// Serial front end writing the 4x16 configuration register bank.
// Oversamples cs_n/sclk/sdi, assembles an 18-bit {adr,dat} frame and issues
// a write with SETUP_CYC/STROBE_CYC/HOLD_CYC framing around reg_wr_o.
// Optional readback of mux_i on sdo_o: define CFG_LOADER_READBACK_EN.
`timescale 1ns/1ps
module config_serial_loader
  import config_serial_loader_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SETUP_CYC   = 2,
  parameter int unsigned STROBE_CYC  = 4,
  parameter int unsigned HOLD_CYC    = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cs_n_i,
  input  logic              sclk_i,
  input  logic              sdi_i,
  output logic              sdo_o,
  input  logic [MUX_W-1:0]  mux_i,
  output logic              reg_wr_o,
  output logic [ADR_W-1:0]  reg_adr_o,
  output logic [DAT_W-1:0]  reg_dat_o,
  output logic              busy_o,
  output logic              frame_err_o
);

  localparam int unsigned MAX_AB  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int unsigned MAX_CYC = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
  localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0] SETUP_LAST  = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0] STROBE_LAST = TMR_W'(STROBE_CYC - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_CYC - 1);

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic sdi_s, sdi_rise, sdi_fall;

  cfg_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk_i (clk_i), .rst_n_i (rst_n_i), .d_i (cs_n_i),
    .q_o (cs_lvl), .rise_o (cs_rise), .fall_o (cs_fall)
  );

  cfg_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk_i (clk_i), .rst_n_i (rst_n_i), .d_i (sclk_i),
    .q_o (sclk_lvl), .rise_o (sclk_rise), .fall_o (sclk_fall)
  );

  // Only the synchronized level of sdi is consumed; its edge outputs are left
  // dangling and trimmed away.
  cfg_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
    .clk_i (clk_i), .rst_n_i (rst_n_i), .d_i (sdi_i),
    .q_o (sdi_s), .rise_o (sdi_rise), .fall_o (sdi_fall)
  );

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [ADR_W-1:0]      adr_q, adr_d;
  logic [DAT_W-1:0]      dat_q, dat_d;
  logic                  wr_q, wr_d;
  logic                  err_q, err_d;
  logic                  blocked_q, blocked_d;
  frame_t                frame_w;
  logic                  busy_w;

  assign frame_w = frame_t'(shift_q);
  assign busy_w  = is_busy_state(state_q);

  // Frame capture and write sequencing FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    tmr_d     = tmr_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    wr_d      = wr_q;
    err_d     = 1'b0;
    blocked_d = blocked_q;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d   = ST_SHIFT;
          cnt_d     = '0;
          shift_d   = '0;
          blocked_d = 1'b0;
        end else if (cs_rise && blocked_q) begin
          // End of a frame that began during a write: reject, never write.
          err_d     = 1'b1;
          blocked_d = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          if (cnt_q == CNT_FULL) begin
            state_d = ST_SETUP;
            adr_d   = frame_w.adr;
            dat_d   = frame_w.dat;
            tmr_d   = '0;
          end else begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end else if (sclk_rise) begin
          shift_d = {shift_q[FRAME_BITS-2:0], sdi_s};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 5'd1;
        end
      end
      ST_SETUP: begin
        if (tmr_q == SETUP_LAST) begin
          state_d = ST_STROBE;
          wr_d    = 1'b1;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_STROBE: begin
        if (tmr_q == STROBE_LAST) begin
          state_d = ST_HOLD;
          wr_d    = 1'b0;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (tmr_q == HOLD_LAST) begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        wr_d    = 1'b0;
        tmr_d   = '0;
      end
    endcase

    // Frames opened while a write is in flight are tracked outside the
    // state encoding so their close can land in either busy or IDLE.
    if (busy_w) begin
      if (cs_fall) begin
        blocked_d = 1'b1;
      end else if (cs_rise && blocked_q) begin
        err_d     = 1'b1;
        blocked_d = 1'b0;
      end
    end
  end

  // FSM, datapath and output registers; reset aborts any write in progress.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      tmr_q     <= '0;
      adr_q     <= '0;
      dat_q     <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      tmr_q     <= tmr_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      wr_q      <= wr_d;
      err_q     <= err_d;
      blocked_q <= blocked_d;
    end
  end

  assign reg_wr_o    = wr_q;
  assign reg_adr_o   = adr_q;
  assign reg_dat_o   = dat_q;
  assign busy_o      = busy_w;
  assign frame_err_o = err_q;

`ifdef CFG_LOADER_READBACK_EN
  logic [MUX_W-1:0] mux_q, mux_d;

  // Snapshot of the observation bus, shifted out MSB first on sclk falls.
  always_comb begin
    mux_d = mux_q;
    if ((state_q == ST_IDLE) && cs_fall) begin
      mux_d = mux_i;
    end else if ((state_q == ST_SHIFT) && sclk_fall) begin
      mux_d = {mux_q[MUX_W-2:0], 1'b0};
    end
  end

  // Readback shift register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) mux_q <= '0;
    else          mux_q <= mux_d;
  end

  assign sdo_o = (state_q == ST_SHIFT) & mux_q[MUX_W-1];

  logic unused_sig;
  assign unused_sig = ^{cs_lvl, sclk_lvl, sdi_rise, sdi_fall};
`else
  assign sdo_o = 1'b0;

  logic unused_sig;
  assign unused_sig = ^{cs_lvl, sclk_lvl, sdi_rise, sdi_fall, sclk_fall, mux_i};
`endif

endmodule

// File: tb/tb_config_serial_loader.sv
// Directed bench for config_serial_loader with hand-computed expectations.
`timescale 1ns/1ps
module tb_config_serial_loader;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        cs_n_i;
  logic        sclk_i;
  logic        sdi_i;
  logic        sdo_o;
  logic [5:0]  mux_i;
  logic        reg_wr_o;
  logic [1:0]  reg_adr_o;
  logic [15:0] reg_dat_o;
  logic        busy_o;
  logic        frame_err_o;

  config_serial_loader #(
    .SYNC_STAGES (2),
    .SETUP_CYC   (2),
    .STROBE_CYC  (4),
    .HOLD_CYC    (2)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .cs_n_i      (cs_n_i),
    .sclk_i      (sclk_i),
    .sdi_i       (sdi_i),
    .sdo_o       (sdo_o),
    .mux_i       (mux_i),
    .reg_wr_o    (reg_wr_o),
    .reg_adr_o   (reg_adr_o),
    .reg_dat_o   (reg_dat_o),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Event counters sampled away from the active edge.
  int unsigned wr_rises   = 0;
  int unsigned err_pulses = 0;
  logic        wr_prev    = 1'b0;

  always @(negedge clk_i) begin
    if (reg_wr_o && !wr_prev) wr_rises++;
    wr_prev = reg_wr_o;
    if (frame_err_o) err_pulses++;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_neg(input int unsigned n);
    repeat (n) @(negedge clk_i);
  endtask

  // Opens a frame and clocks out n bits MSB first; leaves cs_n low.
  task automatic shift_bits(input logic [31:0] bits, input int unsigned n, input bit chk_sdo);
    logic [5:0] m;
    logic       exp_sdo;
    m = mux_i;
    cs_n_i = 1'b0;
    wait_neg(4);
    for (int unsigned i = 0; i < n; i++) begin
      sdi_i = bits[n-1-i];
      wait_neg(4);
      if (chk_sdo) begin
`ifdef CFG_LOADER_READBACK_EN
        exp_sdo = (i < 6) ? m[5-i] : 1'b0;
`else
        exp_sdo = 1'b0;
`endif
        check_eq($sformatf("sdo_bit%0d", i), 32'(sdo_o), 32'(exp_sdo));
      end
      sclk_i = 1'b1;
      wait_neg(4);
      sclk_i = 1'b0;
    end
    wait_neg(4);
  endtask

  int unsigned e0, w0;
  int unsigned wr_cyc, busy_cyc;
  bit          seen;

  initial begin
    rst_n_i = 1'b0;
    cs_n_i  = 1'b1;
    sclk_i  = 1'b0;
    sdi_i   = 1'b0;
    mux_i   = 6'b101101;
    wait_neg(3);
    check_eq("rst_wr",   32'(reg_wr_o),    32'd0);
    check_eq("rst_adr",  32'(reg_adr_o),   32'd0);
    check_eq("rst_dat",  32'(reg_dat_o),   32'd0);
    check_eq("rst_busy", 32'(busy_o),      32'd0);
    check_eq("rst_err",  32'(frame_err_o), 32'd0);
    check_eq("rst_sdo",  32'(sdo_o),       32'd0);
    rst_n_i = 1'b1;
    wait_neg(3);

    // sclk activity with cs_n high must be ignored.
    e0 = err_pulses; w0 = wr_rises;
    for (int i = 0; i < 3; i++) begin
      sclk_i = 1'b1; wait_neg(4); sclk_i = 1'b0; wait_neg(4);
    end
    check_eq("idle_sclk_err", 32'(err_pulses - e0), 32'd0);
    check_eq("idle_sclk_wr",  32'(wr_rises - w0),   32'd0);
    check_eq("idle_sclk_busy", 32'(busy_o),         32'd0);

    // Frame 2/0xA5C3 with cycle-exact write framing after the cs_n rise.
    e0 = err_pulses; w0 = wr_rises;
    shift_bits(32'h0002_A5C3, 18, 1'b1);
    cs_n_i = 1'b1;
    wr_cyc = 0; busy_cyc = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk_i);
      if (k == 2) begin
        check_eq("pre_adr", 32'(reg_adr_o), 32'd0);
        check_eq("pre_dat", 32'(reg_dat_o), 32'd0);
      end
      if (k == 3) begin
        check_eq("frm_adr", 32'(reg_adr_o), 32'd2);
        check_eq("frm_dat", 32'(reg_dat_o), 32'hA5C3);
      end
      check_eq($sformatf("wr_c%0d", k),   32'(reg_wr_o), 32'((k >= 5) && (k <= 8)));
      check_eq($sformatf("busy_c%0d", k), 32'(busy_o),   32'((k >= 3) && (k <= 10)));
      if (reg_wr_o) wr_cyc++;
      if (busy_o) busy_cyc++;
    end
    check_eq("wr_len",   32'(wr_cyc),   32'd4);
    check_eq("busy_len", 32'(busy_cyc), 32'd8);
    check_eq("frm_err",  32'(err_pulses - e0), 32'd0);
    check_eq("frm_wrs",  32'(wr_rises - w0),   32'd1);
    check_eq("post_sdo", 32'(sdo_o), 32'd0);

    // Short then long frame: both rejected, bank untouched.
    e0 = err_pulses; w0 = wr_rises;
    shift_bits(32'h0001_FFFF, 17, 1'b0);
    cs_n_i = 1'b1;
    wait_neg(8);
    check_eq("short_err", 32'(err_pulses - e0), 32'd1);
    shift_bits(32'h0003_1234, 19, 1'b0);
    cs_n_i = 1'b1;
    wait_neg(20);
    check_eq("long_err", 32'(err_pulses - e0), 32'd2);
    check_eq("bad_wr",   32'(wr_rises - w0),   32'd0);
    check_eq("bad_adr",  32'(reg_adr_o), 32'd2);
    check_eq("bad_dat",  32'(reg_dat_o), 32'hA5C3);

    // Frame opened during a write is rejected; the write itself completes.
    e0 = err_pulses; w0 = wr_rises;
    shift_bits(32'h0001_0F0F, 18, 1'b0);
    cs_n_i = 1'b1;
    wait_neg(2);
    cs_n_i = 1'b0;
    wait_neg(3);
    check_eq("blk_busy_at_open", 32'(busy_o), 32'd1);
    shift_bits(32'h0003_1234, 18, 1'b0);
    cs_n_i = 1'b1;
    wait_neg(20);
    check_eq("blk_err", 32'(err_pulses - e0), 32'd1);
    check_eq("blk_wr",  32'(wr_rises - w0),   32'd1);
    check_eq("blk_adr", 32'(reg_adr_o), 32'd1);
    check_eq("blk_dat", 32'(reg_dat_o), 32'h0F0F);

    // Same frame retried once idle is accepted.
    e0 = err_pulses; w0 = wr_rises;
    shift_bits(32'h0003_1234, 18, 1'b1);
    cs_n_i = 1'b1;
    wait_neg(20);
    check_eq("retry_err", 32'(err_pulses - e0), 32'd0);
    check_eq("retry_wr",  32'(wr_rises - w0),   32'd1);
    check_eq("retry_adr", 32'(reg_adr_o), 32'd3);
    check_eq("retry_dat", 32'(reg_dat_o), 32'h1234);

    // Reset asserted during the strobe aborts the write.
    shift_bits(32'h0002_BEEF, 18, 1'b0);
    cs_n_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk_i);
      if (reg_wr_o) seen = 1'b1;
    end
    check_eq("rst_wr_seen", 32'(seen), 32'd1);
    check_eq("rst_pre_dat", 32'(reg_dat_o), 32'hBEEF);
    wait_neg(1);
    rst_n_i = 1'b0;
    #1;
    check_eq("arst_wr",   32'(reg_wr_o),  32'd0);
    check_eq("arst_adr",  32'(reg_adr_o), 32'd0);
    check_eq("arst_dat",  32'(reg_dat_o), 32'd0);
    check_eq("arst_busy", 32'(busy_o),    32'd0);
    wait_neg(2);
    rst_n_i = 1'b1;
    w0 = wr_rises;
    wait_neg(20);
    check_eq("rel_wr",    32'(wr_rises - w0), 32'd0);
    check_eq("rel_busy",  32'(busy_o),        32'd0);
    check_eq("rel_state", 32'(dut.state_q),   32'd0);

    // Normal operation resumes after reset.
    mux_i = 6'b010011;
    e0 = err_pulses; w0 = wr_rises;
    shift_bits(32'h0001_00FF, 18, 1'b1);
    cs_n_i = 1'b1;
    wait_neg(20);
    check_eq("post_wr",  32'(wr_rises - w0), 32'd1);
    check_eq("post_adr", 32'(reg_adr_o), 32'd1);
    check_eq("post_dat", 32'(reg_dat_o), 32'h00FF);
    check_eq("post_err", 32'(err_pulses - e0), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
